// File: rtl/wave_param_ctrl.sv
// Button-driven edit controller for waveform type, frequency and amplitude.
// Define WAVE_PARAM_AUTOREPEAT_EN to build the hold-to-auto-repeat FSM and counter.
module wave_param_ctrl #(
  parameter int WAVE_TYPES    = 4,
  parameter int FREQ_MIN      = 1,
  parameter int FREQ_MAX      = 1000,
  parameter int FREQ_DEFAULT  = 100,
  parameter int FREQ_STEP     = 1,
  parameter int AMP_STEP      = 16,
  parameter int AMP_DEFAULT   = 128,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode_p,
  input  logic        btn_up_p,
  input  logic        btn_down_p,
  input  logic        btn_up_lvl,
  input  logic        btn_down_lvl,
  output logic [1:0]  field_sel,
  output logic [1:0]  wave_sel,
  output logic [15:0] freq_val,
  output logic [7:0]  amp_val,
  output logic        cfg_update
);

  typedef enum logic [1:0] {
    F_WAVE = 2'd0,
    F_FREQ = 2'd1,
    F_AMP  = 2'd2
  } field_t;

  localparam logic [1:0]         WAVE_LAST = 2'(WAVE_TYPES - 1);
  localparam logic signed [17:0] FSTEP_S   = 18'(FREQ_STEP);
  localparam logic signed [17:0] FMIN_S    = 18'(FREQ_MIN);
  localparam logic signed [17:0] FMAX_S    = 18'(FREQ_MAX);
  localparam logic [15:0]        FMIN_U    = 16'(FREQ_MIN);
  localparam logic [15:0]        FMAX_U    = 16'(FREQ_MAX);
  localparam logic signed [9:0]  ASTEP_S   = 10'(AMP_STEP);
  localparam logic signed [9:0]  AMAX_S    = 10'sd255;

  function automatic logic [1:0] wrap_wave(input logic [1:0] w, input logic up);
    if (up) return (w == WAVE_LAST) ? 2'd0 : w + 2'd1;
    return (w == 2'd0) ? WAVE_LAST : w - 2'd1;
  endfunction

  function automatic logic [15:0] sat_freq(input logic [15:0] f, input logic up);
    logic signed [17:0] t;
    t = $signed({2'b00, f}) + (up ? FSTEP_S : -FSTEP_S);
    if (t > FMAX_S) return FMAX_U;
    if (t < FMIN_S) return FMIN_U;
    return t[15:0];
  endfunction

  function automatic logic [7:0] sat_amp(input logic [7:0] a, input logic up);
    logic signed [9:0] t;
    t = $signed({2'b00, a}) + (up ? ASTEP_S : -ASTEP_S);
    if (t > AMAX_S) return 8'hff;
    if (t < 10'sd0) return 8'h00;
    return t[7:0];
  endfunction

  field_t      field_p0, field_nxt;
  logic [1:0]  wave_p0, wave_nxt;
  logic [15:0] freq_p0, freq_nxt;
  logic [7:0]  amp_p0, amp_nxt;
  logic        upd_p0, upd_nxt;

  logic press_acc;
  logic rep_step;
  logic step_req;
  logic step_up;

  // mode wins over up/down; simultaneous up+down cancels
  assign press_acc = !btn_mode_p && (btn_up_p ^ btn_down_p);

`ifdef WAVE_PARAM_AUTOREPEAT_EN
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_HOLD   = 2'd1,
    RS_REPEAT = 2'd2
  } rep_state_t;

  rep_state_t       rs_p0, rs_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             dir_p0, dir_nxt;
  logic             lat_lvl, opp_lvl, rep_field, rep_break;

  always_comb begin
    rs_nxt    = rs_p0;
    cnt_nxt   = cnt_p0;
    dir_nxt   = dir_p0;
    rep_step  = 1'b0;
    lat_lvl   = dir_p0 ? btn_up_lvl : btn_down_lvl;
    opp_lvl   = dir_p0 ? btn_down_lvl : btn_up_lvl;
    rep_field = (field_p0 == F_FREQ) || (field_p0 == F_AMP);
    rep_break = btn_mode_p || btn_up_p || btn_down_p || !lat_lvl || opp_lvl;
    case (rs_p0)
      RS_HOLD: begin
        if (rep_break) begin
          rs_nxt  = RS_IDLE;
          cnt_nxt = '0;
        end else if (cnt_p0 == HOLD_LAST) begin
          rep_step = 1'b1;
          rs_nxt   = RS_REPEAT;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      RS_REPEAT: begin
        if (rep_break) begin
          rs_nxt  = RS_IDLE;
          cnt_nxt = '0;
        end else if (cnt_p0 == REP_LAST) begin
          rep_step = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // an accepted press always restarts the hold timer, from any state
    if (press_acc && rep_field) begin
      rs_nxt  = RS_HOLD;
      dir_nxt = btn_up_p;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_p0  <= RS_IDLE;
      cnt_p0 <= '0;
      dir_p0 <= 1'b0;
    end else begin
      rs_p0  <= rs_nxt;
      cnt_p0 <= cnt_nxt;
      dir_p0 <= dir_nxt;
    end
  end

  assign step_up = press_acc ? btn_up_p : dir_p0;
`else
  logic unused_lvl;
  assign unused_lvl = btn_up_lvl ^ btn_down_lvl;
  assign rep_step   = 1'b0;
  assign step_up    = btn_up_p;
`endif

  assign step_req = press_acc || rep_step;

  always_comb begin
    field_nxt = field_p0;
    if (btn_mode_p) begin
      case (field_p0)
        F_WAVE:  field_nxt = F_FREQ;
        F_FREQ:  field_nxt = F_AMP;
        default: field_nxt = F_WAVE;
      endcase
    end
  end

  always_comb begin
    wave_nxt = wave_p0;
    freq_nxt = freq_p0;
    amp_nxt  = amp_p0;
    if (step_req) begin
      case (field_p0)
        F_WAVE:  wave_nxt = wrap_wave(wave_p0, step_up);
        F_FREQ:  freq_nxt = sat_freq(freq_p0, step_up);
        F_AMP:   amp_nxt  = sat_amp(amp_p0, step_up);
        default: ;
      endcase
    end
    upd_nxt = (wave_nxt != wave_p0) || (freq_nxt != freq_p0) || (amp_nxt != amp_p0);
  end

  // p0: registered configuration outputs, one cycle after the sampled press
  always_ff @(posedge clk) begin
    if (rst) begin
      field_p0 <= F_WAVE;
      wave_p0  <= 2'd0;
      freq_p0  <= 16'(FREQ_DEFAULT);
      amp_p0   <= 8'(AMP_DEFAULT);
      upd_p0   <= 1'b0;
    end else begin
      field_p0 <= field_nxt;
      wave_p0  <= wave_nxt;
      freq_p0  <= freq_nxt;
      amp_p0   <= amp_nxt;
      upd_p0   <= upd_nxt;
    end
  end

  assign field_sel  = field_p0;
  assign wave_sel   = wave_p0;
  assign freq_val   = freq_p0;
  assign amp_val    = amp_p0;
  assign cfg_update = upd_p0;

endmodule

// File: tb/tb_wave_param_ctrl.sv
// Self-checking bench for wave_param_ctrl: directed scenarios plus randomized
// stimulus against a time-based behavioural model of the controller.
module tb_wave_param_ctrl;
  localparam int WT    = 4;
  localparam int FMIN  = 1;
  localparam int FMAX  = 1000;
  localparam int FDEF  = 100;
  localparam int FSTEP = 1;
  localparam int ASTEP = 16;
  localparam int ADEF  = 128;
  localparam int HOLD  = 20;
  localparam int REP   = 5;
`ifdef WAVE_PARAM_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode_p = 1'b0, btn_up_p = 1'b0, btn_down_p = 1'b0;
  logic        btn_up_lvl = 1'b0, btn_down_lvl = 1'b0;
  logic [1:0]  field_sel, wave_sel;
  logic [15:0] freq_val;
  logic [7:0]  amp_val;
  logic        cfg_update;

  always #5 clk = ~clk;

  wave_param_ctrl #(
    .WAVE_TYPES(WT), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .FREQ_DEFAULT(FDEF),
    .FREQ_STEP(FSTEP), .AMP_STEP(ASTEP), .AMP_DEFAULT(ADEF),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode_p(btn_mode_p), .btn_up_p(btn_up_p),
    .btn_down_p(btn_down_p), .btn_up_lvl(btn_up_lvl), .btn_down_lvl(btn_down_lvl),
    .field_sel(field_sel), .wave_sel(wave_sel), .freq_val(freq_val),
    .amp_val(amp_val), .cfg_update(cfg_update)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: plain integers and the time elapsed since the press
  int m_field, m_wave, m_freq, m_amp;
  bit m_upd;
  bit h_on, h_up;
  int h_el;

  task automatic model_reset();
    m_field = 0; m_wave = 0; m_freq = FDEF; m_amp = ADEF; m_upd = 1'b0;
    h_on = 1'b0; h_up = 1'b0; h_el = 0;
  endtask

  task automatic model_edge(input bit md, input bit up, input bit dn, input bit ul, input bit dl);
    int ow, of, oa;
    bit step, sdir, acc;
    if (rst) begin
      model_reset();
    end else begin
      ow = m_wave; of = m_freq; oa = m_amp;
      step = 1'b0; sdir = 1'b0;
      acc = !md && (up != dn);
      if (AR_EN && h_on) begin
        if (!md && !up && !dn && (h_up ? ul : dl) && !(h_up ? dl : ul)) begin
          h_el++;
          if (h_el == HOLD || (h_el > HOLD && ((h_el - HOLD) % REP) == 0)) begin
            step = 1'b1; sdir = h_up;
          end
        end else begin
          h_on = 1'b0;
        end
      end
      if (AR_EN && acc && (m_field == 1 || m_field == 2)) begin
        h_on = 1'b1; h_up = up; h_el = 0;
      end
      if (acc) begin step = 1'b1; sdir = up; end
      if (step) begin
        case (m_field)
          0: m_wave = (m_wave + (sdir ? 1 : WT - 1)) % WT;
          1: m_freq = sdir ? ((m_freq + FSTEP > FMAX) ? FMAX : m_freq + FSTEP)
                           : ((m_freq - FSTEP < FMIN) ? FMIN : m_freq - FSTEP);
          default: m_amp = sdir ? ((m_amp + ASTEP > 255) ? 255 : m_amp + ASTEP)
                                : ((m_amp - ASTEP < 0) ? 0 : m_amp - ASTEP);
        endcase
      end
      if (md) m_field = (m_field + 1) % 3;
      m_upd = (ow != m_wave) || (of != m_freq) || (oa != m_amp);
    end
  endtask

  function automatic logic [28:0] exp_vec();
    return {m_field[1:0], m_wave[1:0], m_freq[15:0], m_amp[7:0], m_upd};
  endfunction

  task automatic drive(input bit md, input bit up, input bit dn, input bit ul, input bit dl);
    btn_mode_p = md; btn_up_p = up; btn_down_p = dn; btn_up_lvl = ul; btn_down_lvl = dl;
    @(posedge clk);
    #1;
    model_edge(md, up, dn, ul, dl);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    n_checks++;
    if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== {2'd0, 2'd0, 16'd100, 8'd128, 1'b0}) begin
      n_errors++;
      $display("FAIL reset: got %h required %h", {field_sel, wave_sel, freq_val, amp_val, cfg_update},
               {2'd0, 2'd0, 16'd100, 8'd128, 1'b0});
    end
  endtask

  task automatic test_field_cycle();
    int fl[3] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      n_checks++;
      if (field_sel !== fl[i][1:0] || cfg_update !== 1'b0) begin
        n_errors++;
        $display("FAIL field_cycle[%0d]: field %0d upd %b required %0d upd 0", i, field_sel, cfg_update, fl[i]);
      end
    end
  endtask

  task automatic test_wave_wrap();
    drive(0, 0, 1, 0, 1);
    n_checks++;
    if (wave_sel !== 2'd3 || cfg_update !== 1'b1) begin
      n_errors++;
      $display("FAIL wave_down: wave %0d upd %b required 3 upd 1", wave_sel, cfg_update);
    end
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (cfg_update !== 1'b0 || wave_sel !== 2'd3) begin
      n_errors++;
      $display("FAIL wave_strobe_len: wave %0d upd %b required 3 upd 0", wave_sel, cfg_update);
    end
    drive(0, 1, 0, 1, 0);
    n_checks++;
    if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec() || wave_sel !== 2'd0) begin
      n_errors++;
      $display("FAIL wave_up: got %h required %h", {field_sel, wave_sel, freq_val, amp_val, cfg_update}, exp_vec());
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_amp_sat();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0, 0);
      n_checks++;
      if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec()) begin
        n_errors++;
        $display("FAIL amp_step[%0d]: got %h required %h", i, {field_sel, wave_sel, freq_val, amp_val, cfg_update}, exp_vec());
      end
      if (i >= 7) begin
        n_checks++;
        if (amp_val !== 8'd255 || cfg_update !== (i == 7)) begin
          n_errors++;
          $display("FAIL amp_sat[%0d]: amp %0d upd %b required 255 upd %b", i, amp_val, cfg_update, i == 7);
        end
      end
      drive(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_autorepeat();
    int want;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k <= 60; k++) begin
      if (k == 0) drive(0, 1, 0, 1, 0);
      else if (k <= 40) drive(0, 0, 0, 1, 0);
      else drive(0, 0, 0, 0, 0);
      want = 101;
      if (AR_EN && k >= 20) want = 102 + (((k > 40) ? 40 : k) - 20) / 5;
      n_checks++;
      if (freq_val !== 16'(want) || {field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec()) begin
        n_errors++;
        $display("FAIL autorepeat[k=%0d]: freq %0d vec %h required freq %0d vec %h", k, freq_val,
                 {field_sel, wave_sel, freq_val, amp_val, cfg_update}, want, exp_vec());
      end
    end
  endtask

  task automatic test_priority();
    logic [15:0] f0;
    logic [7:0]  a0;
    f0 = freq_val; a0 = amp_val;
    drive(1, 1, 0, 1, 0);
    n_checks++;
    if (field_sel !== 2'd2 || freq_val !== f0 || amp_val !== a0 || cfg_update !== 1'b0) begin
      n_errors++;
      $display("FAIL mode_wins: field %0d freq %0d amp %0d upd %b required 2 %0d %0d 0",
               field_sel, freq_val, amp_val, cfg_update, f0, a0);
    end
    drive(0, 1, 1, 0, 0);
    n_checks++;
    if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec() || amp_val !== a0 || cfg_update !== 1'b0) begin
      n_errors++;
      $display("FAIL up_down_cancel: got %h required %h", {field_sel, wave_sel, freq_val, amp_val, cfg_update}, exp_vec());
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_in_repeat();
    int want;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 48; i++) begin
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    drive(0, 1, 0, 1, 0);
    for (int k = 1; k <= 22; k++) drive(0, 0, 0, 1, 0);
    want = AR_EN ? 150 : 149;
    n_checks++;
    if (freq_val !== 16'(want) || {field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec()) begin
      n_errors++;
      $display("FAIL pre_reset_freq: freq %0d required %0d", freq_val, want);
    end
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    rst = 1'b0;
    n_checks++;
    if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== {2'd0, 2'd0, 16'd100, 8'd128, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_in_repeat: got %h required %h", {field_sel, wave_sel, freq_val, amp_val, cfg_update},
               {2'd0, 2'd0, 16'd100, 8'd128, 1'b0});
    end
    for (int k = 0; k < 30; k++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (freq_val !== 16'd100 || cfg_update !== 1'b0 || {field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec()) begin
        n_errors++;
        $display("FAIL post_reset_idle[%0d]: freq %0d upd %b required 100 upd 0", k, freq_val, cfg_update);
      end
    end
  endtask

  task automatic test_random();
    bit ul, dl;
    ul = 1'b0; dl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) ul = !ul;
      if ($urandom_range(0, 29) == 0) dl = !dl;
      rst = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 47) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0, ul, dl);
      rst = 1'b0;
      n_checks++;
      if ({field_sel, wave_sel, freq_val, amp_val, cfg_update} !== exp_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h required %h", c, {field_sel, wave_sel, freq_val, amp_val, cfg_update}, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_field_cycle();
    test_wave_wrap();
    test_amp_sat();
    test_autorepeat();
    test_priority();
    test_reset_in_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
